// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and width helper for the Huffman bit packer.
//   pk_state_t : packer control states (run, flush, last-word wait, done pulse)
//   width_for  : number of bits needed to hold the value n (minimum 1)
package huffman_pkg;

    typedef enum logic [1:0] {
        PK_RUN,
        PK_FLUSH,
        PK_LAST,
        PK_DONE
    } pk_state_t;

    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// packer_out_reg: single-entry output buffer holding word/last/last_bits behind a valid/ready pair.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   load                  capture load_word/load_last/load_bits; caller guarantees the slot is free
//   load_word/last/bits   next word, final-word flag and final-word bit count
//   word_ready            downstream accepts the held word
//   word_out/valid/last   buffered word, valid flag and final-word flag
//   last_bits             meaningful bits of the final word, 0 for any other word
module packer_out_reg #(
    parameter int WORD_W = 8,
    parameter int BW     = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              load_last,
    input  logic [BW-1:0]     load_bits,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              word_last,
    output logic [BW-1:0]     last_bits
);

    logic [WORD_W-1:0] r_word;
    logic              r_valid;
    logic              r_last;
    logic [BW-1:0]     r_bits;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_bits  <= '0;
        end else if (load) begin
            r_word  <= load_word;
            r_valid <= 1'b1;
            r_last  <= load_last;
            r_bits  <= load_bits;
        end else if (r_valid && word_ready) begin
            // Drop the final-word qualifiers once the word leaves so they never linger.
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_bits  <= '0;
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign word_last  = r_last;
    assign last_bits  = r_bits;

endmodule

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length codewords MSB-first into WORD_W-bit words with
// valid/ready on both sides, end-of-stream flush with zero padding and a final-word bit count.
// Optional feature macro: HUFF_PACK_WORD_COUNT_EN adds word_count[31:0] (output transfers since
// reset, cleared the cycle after the done pulse).
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   code_in, code_len          right-aligned codeword and its length (clamped to MAX_LEN)
//   code_valid, code_ready     input handshake
//   flush                      end-of-stream pulse, honoured only while running
//   word_out, word_valid       packed word and its valid, held until word_ready
//   word_ready                 downstream accept
//   word_last, last_bits       final-word flag and its meaningful bit count
//   done                       one-cycle pulse once the stream is fully drained
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int MAX_LEN = 16,
    localparam int LW     = width_for(MAX_LEN),
    localparam int BW     = width_for(WORD_W)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [MAX_LEN-1:0] code_in,
    input  logic [LW-1:0]      code_len,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic               flush,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               word_last,
    output logic [BW-1:0]      last_bits,
`ifdef HUFF_PACK_WORD_COUNT_EN
    output logic [31:0]        word_count,
`endif
    output logic               done
);

    localparam int ACC_W = WORD_W + MAX_LEN;
    localparam int FW    = width_for(ACC_W - 1);
    localparam logic [FW-1:0] WF = FW'(WORD_W);

    pk_state_t         r_state, w_state_n;
    logic [ACC_W-1:0]  r_acc, w_acc_n, w_code;
    logic [FW-1:0]     r_fill, w_fill_n, w_fill_d, w_rem;
    logic [LW-1:0]     w_len;
    logic              r_live;
    logic              w_accept, w_free, w_xfer, w_full;
    logic              w_load, w_ld_last;
    logic [WORD_W-1:0] w_ld_word;
    logic [BW-1:0]     w_ld_bits;

    // r_live keeps code_ready low while reset is asserted and for the first cycle after it.
    assign code_ready = r_live && (r_state == PK_RUN) && (r_fill < WF);
    assign done       = (r_state == PK_DONE);

    assign w_accept = code_valid && code_ready;
    assign w_xfer   = word_valid && word_ready;
    assign w_free   = !word_valid || word_ready;
    assign w_len    = (code_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : code_len;
    assign w_code   = ACC_W'(code_in) & ~({ACC_W{1'b1}} << w_len);

    // Post-accept view, so a completing code yields its word on the very next cycle.
    assign w_acc_n  = w_accept ? ((r_acc << w_len) | w_code) : r_acc;
    assign w_fill_n = w_accept ? (r_fill + FW'(w_len)) : r_fill;
    assign w_full   = (w_fill_n >= WF);
    assign w_rem    = w_fill_n - WF;

    always_comb begin
        w_state_n = r_state;
        w_fill_d  = w_fill_n;
        w_load    = 1'b0;
        w_ld_last = 1'b0;
        w_ld_bits = '0;
        w_ld_word = WORD_W'(w_acc_n >> w_rem);
        case (r_state)
            PK_RUN: begin
                if (w_full && w_free) begin
                    w_load   = 1'b1;
                    w_fill_d = w_rem;
                end
                if (flush)
                    w_state_n = PK_FLUSH;
            end
            PK_FLUSH: begin
                if (w_full) begin
                    if (w_free) begin
                        w_load   = 1'b1;
                        w_fill_d = w_rem;
                        // A full word that empties the accumulator is the final word.
                        if (w_rem == '0) begin
                            w_ld_last = 1'b1;
                            w_ld_bits = BW'(WORD_W);
                            w_state_n = PK_LAST;
                        end
                    end
                end else if (w_fill_n != '0) begin
                    if (w_free) begin
                        w_load    = 1'b1;
                        w_ld_word = WORD_W'(w_acc_n << (WF - w_fill_n));
                        w_ld_last = 1'b1;
                        w_ld_bits = BW'(w_fill_n);
                        w_fill_d  = '0;
                        w_state_n = PK_LAST;
                    end
                end else if (w_free) begin
                    w_state_n = PK_DONE;
                end
            end
            PK_LAST: begin
                if (w_xfer)
                    w_state_n = PK_DONE;
            end
            PK_DONE: begin
                w_fill_d  = '0;
                w_state_n = PK_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= PK_RUN;
            r_acc   <= '0;
            r_fill  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_fill  <= w_fill_d;
            r_live  <= 1'b1;
        end
    end

`ifdef HUFF_PACK_WORD_COUNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_word_count <= '0;
        else if (r_state == PK_DONE)
            r_word_count <= '0;
        else if (w_xfer)
            r_word_count <= r_word_count + 32'd1;
    end

    assign word_count = r_word_count;
`endif

    packer_out_reg #(
        .WORD_W (WORD_W),
        .BW     (BW)
    ) u_out_reg (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (w_load),
        .load_word  (w_ld_word),
        .load_last  (w_ld_last),
        .load_bits  (w_ld_bits),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_last  (word_last),
        .last_bits  (last_bits)
    );

endmodule
